// File: rtl/dot_prod_engine_if.sv
// Host-side bundle for dot_prod_engine: the start/result handshake and the
// two operand-array load/readback ports.
interface dot_prod_engine_if #(
    parameter int ELEM_W = 27,
    parameter int ADDR_W = 10,
    parameter int ACC_W  = 64
);
    logic              r_enable;
    logic [ADDR_W-1:0] init_i;
    logic [ADDR_W:0]   init_len;
    logic [ACC_W-1:0]  init_acc;
    logic              w_enable;
    logic [ACC_W-1:0]  result;
    logic              busy;

    logic              controlArr;
    logic              controlArrWEnable_a;
    logic              controlArrWEnable_b;
    logic [ADDR_W-1:0] controlArrAddr_a;
    logic [ADDR_W-1:0] controlArrAddr_b;
    logic [ELEM_W-1:0] controlArrWData_a;
    logic [ELEM_W-1:0] controlArrWData_b;
    logic [ELEM_W-1:0] controlArrRData_a;
    logic [ELEM_W-1:0] controlArrRData_b;

    modport master (
        output r_enable, init_i, init_len, init_acc,
        output controlArr, controlArrWEnable_a, controlArrWEnable_b,
        output controlArrAddr_a, controlArrAddr_b,
        output controlArrWData_a, controlArrWData_b,
        input  w_enable, result, busy,
        input  controlArrRData_a, controlArrRData_b
    );

    modport slave (
        input  r_enable, init_i, init_len, init_acc,
        input  controlArr, controlArrWEnable_a, controlArrWEnable_b,
        input  controlArrAddr_a, controlArrAddr_b,
        input  controlArrWData_a, controlArrWData_b,
        output w_enable, result, busy,
        output controlArrRData_a, controlArrRData_b
    );
endinterface

// File: rtl/dot_prod_engine.sv
// Windowed dot product over two on-chip operand arrays: address issue, RAM read
// plus multiply, then accumulate; result is posted with a one-cycle w_enable strobe.
module dot_prod_engine #(
    parameter int ELEM_W = 27,
    parameter int ADDR_W = 10,
    parameter int ACC_W  = 64,
    parameter bit SIGNED = 1'b1
) (
    input logic               clk,
    input logic               rst_n,
    dot_prod_engine_if.slave  bus
);
    localparam int DEPTH  = 1 << ADDR_W;
    localparam int PROD_W = 2 * ELEM_W;
    localparam int EXT_W  = ACC_W - PROD_W;

    typedef enum logic [1:0] {IDLE, RUN, DRAIN, DONE} state_t;

    state_t            state_reg;
    logic [ADDR_W-1:0] addr_reg;
    logic [ADDR_W:0]   remain_reg;
    logic              v1_reg;
    logic              v2_reg;
    logic [PROD_W-1:0] prod_reg;
    logic [ACC_W-1:0]  acc_reg;
    logic [ACC_W-1:0]  result_reg;
    logic              w_enable_reg;
    logic              busy_reg;

    logic              host_sel;
    logic              start;
    logic              ram_we    [2];
    logic [ADDR_W-1:0] ram_addr  [2];
    logic [ELEM_W-1:0] ram_wdata [2];
    logic [ELEM_W-1:0] ram_q     [2];
    logic [PROD_W-1:0] op_a_x;
    logic [PROD_W-1:0] op_b_x;
    logic [PROD_W-1:0] prod_next;
    logic [ACC_W-1:0]  prod_acc;

    // The host only owns the arrays while the engine is parked in IDLE.
    assign host_sel = bus.controlArr && (state_reg == IDLE);
    assign start    = bus.r_enable && !bus.controlArr && (state_reg == IDLE);

    assign ram_we[0]    = host_sel && bus.controlArrWEnable_a;
    assign ram_we[1]    = host_sel && bus.controlArrWEnable_b;
    assign ram_addr[0]  = host_sel ? bus.controlArrAddr_a : addr_reg;
    assign ram_addr[1]  = host_sel ? bus.controlArrAddr_b : addr_reg;
    assign ram_wdata[0] = bus.controlArrWData_a;
    assign ram_wdata[1] = bus.controlArrWData_b;

    genvar gi;
    generate
        for (gi = 0; gi < 2; gi++) begin : g_ram
            logic [ELEM_W-1:0] mem [DEPTH];
            logic [ELEM_W-1:0] q_reg;

            always_ff @(posedge clk) begin
                if (ram_we[gi]) begin
                    mem[ram_addr[gi]] <= ram_wdata[gi];
                end
                q_reg <= mem[ram_addr[gi]];
            end

            assign ram_q[gi] = q_reg;
        end

        // Extending to 2*ELEM_W before multiplying gives the exact product in either mode.
        if (SIGNED) begin : g_signed_ops
            assign op_a_x = {{ELEM_W{ram_q[0][ELEM_W-1]}}, ram_q[0]};
            assign op_b_x = {{ELEM_W{ram_q[1][ELEM_W-1]}}, ram_q[1]};
        end else begin : g_unsigned_ops
            assign op_a_x = {{ELEM_W{1'b0}}, ram_q[0]};
            assign op_b_x = {{ELEM_W{1'b0}}, ram_q[1]};
        end

        if (EXT_W > 0) begin : g_prod_ext
            assign prod_acc = {{EXT_W{SIGNED & prod_reg[PROD_W-1]}}, prod_reg};
        end else begin : g_prod_noext
            assign prod_acc = prod_reg;
        end
    endgenerate

    assign prod_next = op_a_x * op_b_x;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_reg    <= IDLE;
            addr_reg     <= '0;
            remain_reg   <= '0;
            v1_reg       <= 1'b0;
            v2_reg       <= 1'b0;
            prod_reg     <= '0;
            acc_reg      <= '0;
            result_reg   <= '0;
            w_enable_reg <= 1'b0;
            busy_reg     <= 1'b0;
        end else begin
            w_enable_reg <= 1'b0;
            v1_reg       <= (state_reg == RUN);
            v2_reg       <= v1_reg;
            if (v1_reg) begin
                prod_reg <= prod_next;
            end
            if (v2_reg) begin
                acc_reg <= acc_reg + prod_acc;
            end

            case (state_reg)
                IDLE: begin
                    busy_reg <= 1'b0;
                    if (start) begin
                        busy_reg   <= 1'b1;
                        addr_reg   <= bus.init_i;
                        remain_reg <= bus.init_len;
                        acc_reg    <= bus.init_acc;
                        state_reg  <= (bus.init_len == '0) ? DONE : RUN;
                    end
                end
                RUN: begin
                    addr_reg   <= addr_reg + 1'b1;
                    remain_reg <= remain_reg - 1'b1;
                    if (remain_reg == (ADDR_W+1)'(1)) begin
                        state_reg <= DRAIN;
                    end
                end
                DRAIN: begin
                    // Once stage 1 is empty, the last product lands in acc on this edge.
                    if (!v1_reg) begin
                        state_reg <= DONE;
                    end
                end
                DONE: begin
                    w_enable_reg <= 1'b1;
                    result_reg   <= acc_reg;
                    state_reg    <= IDLE;
                end
                default: state_reg <= IDLE;
            endcase
        end
    end

    assign bus.w_enable          = w_enable_reg;
    assign bus.result            = result_reg;
    assign bus.busy              = busy_reg;
    assign bus.controlArrRData_a = ram_q[0];
    assign bus.controlArrRData_b = ram_q[1];

endmodule

// File: tb/tb_dot_prod_engine.sv
// Directed bench for dot_prod_engine: a default-size signed instance and a
// 16-deep unsigned instance, sharing one clock and reset.
module tb_dot_prod_engine;
    localparam int EW  = 27;
    localparam int AW  = 10;
    localparam int CW  = 64;
    localparam int AWB = 4;

    logic clk   = 1'b0;
    logic rst_n = 1'b0;

    int n_cmp  = 0;
    int n_fail = 0;
    int cyc    = 0;
    int t0     = 0;
    int wen_a  = 0;
    int wen_b  = 0;

    logic [EW-1:0] mem_a [1024];
    logic [EW-1:0] mem_b [1024];
    longint        exp1;

    dot_prod_engine_if #(.ELEM_W(EW), .ADDR_W(AW),  .ACC_W(CW)) bus_a ();
    dot_prod_engine_if #(.ELEM_W(EW), .ADDR_W(AWB), .ACC_W(CW)) bus_b ();

    dot_prod_engine #(.ELEM_W(EW), .ADDR_W(AW), .ACC_W(CW), .SIGNED(1'b1)) dut_a (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus_a)
    );

    dot_prod_engine #(.ELEM_W(EW), .ADDR_W(AWB), .ACC_W(CW), .SIGNED(1'b0)) dut_b (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus_b)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    always @(negedge clk) begin
        if (bus_a.w_enable) wen_a <= wen_a + 1;
        if (bus_b.w_enable) wen_b <= wen_b + 1;
    end

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    function automatic longint model_a(input int i, input int len, input longint acc);
        longint s;
        s = acc;
        for (int k = 0; k < len; k++) begin
            s += longint'($signed(mem_a[(i + k) % 1024])) * longint'($signed(mem_b[(i + k) % 1024]));
        end
        return s;
    endfunction

    task automatic host_wr_a(input int addr, input logic [EW-1:0] da, input logic [EW-1:0] db);
        @(negedge clk);
        bus_a.controlArr          = 1'b1;
        bus_a.controlArrWEnable_a = 1'b1;
        bus_a.controlArrWEnable_b = 1'b1;
        bus_a.controlArrAddr_a    = AW'(addr);
        bus_a.controlArrAddr_b    = AW'(addr);
        bus_a.controlArrWData_a   = da;
        bus_a.controlArrWData_b   = db;
    endtask

    task automatic host_idle_a();
        @(negedge clk);
        bus_a.controlArr          = 1'b0;
        bus_a.controlArrWEnable_a = 1'b0;
        bus_a.controlArrWEnable_b = 1'b0;
    endtask

    task automatic host_rd_a(input int addr, output logic [EW-1:0] da, output logic [EW-1:0] db);
        @(negedge clk);
        bus_a.controlArr          = 1'b1;
        bus_a.controlArrWEnable_a = 1'b0;
        bus_a.controlArrWEnable_b = 1'b0;
        bus_a.controlArrAddr_a    = AW'(addr);
        bus_a.controlArrAddr_b    = AW'(addr);
        @(posedge clk);
        #1;
        da = bus_a.controlArrRData_a;
        db = bus_a.controlArrRData_b;
    endtask

    task automatic start_a(input int i, input int len, input longint acc);
        @(negedge clk);
        bus_a.controlArr          = 1'b0;
        bus_a.controlArrWEnable_a = 1'b0;
        bus_a.controlArrWEnable_b = 1'b0;
        bus_a.r_enable            = 1'b1;
        bus_a.init_i              = AW'(i);
        bus_a.init_len            = (AW+1)'(len);
        bus_a.init_acc            = acc;
        @(posedge clk);
        #1;
        t0 = cyc;
        check("start_busy_a", {63'd0, bus_a.busy}, 64'd1);
        @(negedge clk);
        bus_a.r_enable = 1'b0;
    endtask

    task automatic wait_a(input string tag, input int exp_lat, input logic [63:0] exp_res);
        int lat;
        int w0;
        lat = -1;
        w0  = wen_a;
        for (int k = 0; k < 1200; k++) begin
            @(posedge clk);
            #1;
            if (bus_a.w_enable) begin
                lat = cyc - t0;
                break;
            end
        end
        check({tag, "_latency"}, 64'(lat), 64'(exp_lat));
        check({tag, "_result"}, bus_a.result, exp_res);
        check({tag, "_busy_at_done"}, {63'd0, bus_a.busy}, 64'd1);
        @(posedge clk);
        #1;
        check({tag, "_strobe_width"}, {63'd0, bus_a.w_enable}, 64'd0);
        check({tag, "_busy_after"}, {63'd0, bus_a.busy}, 64'd0);
        check({tag, "_result_held"}, bus_a.result, exp_res);
        check({tag, "_strobe_count"}, 64'(wen_a - w0), 64'd1);
    endtask

    task automatic host_wr_b(input int addr, input logic [EW-1:0] da, input logic [EW-1:0] db);
        @(negedge clk);
        bus_b.controlArr          = 1'b1;
        bus_b.controlArrWEnable_a = 1'b1;
        bus_b.controlArrWEnable_b = 1'b1;
        bus_b.controlArrAddr_a    = AWB'(addr);
        bus_b.controlArrAddr_b    = AWB'(addr);
        bus_b.controlArrWData_a   = da;
        bus_b.controlArrWData_b   = db;
        @(negedge clk);
        bus_b.controlArr          = 1'b0;
        bus_b.controlArrWEnable_a = 1'b0;
        bus_b.controlArrWEnable_b = 1'b0;
    endtask

    task automatic run_b(input string tag, input int i, input int len, input longint acc,
                         input int exp_lat, input logic [63:0] exp_res);
        int lat;
        int w0;
        lat = -1;
        w0  = wen_b;
        @(negedge clk);
        bus_b.r_enable = 1'b1;
        bus_b.init_i   = AWB'(i);
        bus_b.init_len = (AWB+1)'(len);
        bus_b.init_acc = acc;
        @(posedge clk);
        #1;
        t0 = cyc;
        @(negedge clk);
        bus_b.r_enable = 1'b0;
        for (int k = 0; k < 200; k++) begin
            @(posedge clk);
            #1;
            if (bus_b.w_enable) begin
                lat = cyc - t0;
                break;
            end
        end
        check({tag, "_latency"}, 64'(lat), 64'(exp_lat));
        check({tag, "_result"}, bus_b.result, exp_res);
        @(posedge clk);
        #1;
        check({tag, "_strobe_width"}, {63'd0, bus_b.w_enable}, 64'd0);
        check({tag, "_strobe_count"}, 64'(wen_b - w0), 64'd1);
    endtask

    initial begin
        logic [EW-1:0] ra;
        logic [EW-1:0] rb;
        int            w0;

        bus_a.r_enable = 1'b0; bus_a.init_i = '0; bus_a.init_len = '0; bus_a.init_acc = '0;
        bus_a.controlArr = 1'b0; bus_a.controlArrWEnable_a = 1'b0; bus_a.controlArrWEnable_b = 1'b0;
        bus_a.controlArrAddr_a = '0; bus_a.controlArrAddr_b = '0;
        bus_a.controlArrWData_a = '0; bus_a.controlArrWData_b = '0;
        bus_b.r_enable = 1'b0; bus_b.init_i = '0; bus_b.init_len = '0; bus_b.init_acc = '0;
        bus_b.controlArr = 1'b0; bus_b.controlArrWEnable_a = 1'b0; bus_b.controlArrWEnable_b = 1'b0;
        bus_b.controlArrAddr_a = '0; bus_b.controlArrAddr_b = '0;
        bus_b.controlArrWData_a = '0; bus_b.controlArrWData_b = '0;

        repeat (3) @(posedge clk);
        #1;
        check("reset_w_enable", {63'd0, bus_a.w_enable}, 64'd0);
        check("reset_busy", {63'd0, bus_a.busy}, 64'd0);
        check("reset_result", bus_a.result, 64'd0);
        @(negedge clk);
        rst_n = 1'b1;

        // Random signed operands across the whole array.
        for (int k = 0; k < 1024; k++) begin
            mem_a[k] = EW'($urandom);
            mem_b[k] = EW'($urandom);
            host_wr_a(k, mem_a[k], mem_b[k]);
        end
        host_rd_a(1023, ra, rb);
        check("load_readback_a", 64'(ra), 64'(mem_a[1023]));
        check("load_readback_b", 64'(rb), 64'(mem_b[1023]));
        mem_a[1000] = 27'h5A5A5A5;
        mem_b[1000] = 27'h0123456;
        host_wr_a(1000, mem_a[1000], mem_b[1000]);
        host_rd_a(1000, ra, rb);
        check("write_then_read_a", 64'(ra), 64'(mem_a[1000]));
        check("write_then_read_b", 64'(rb), 64'(mem_b[1000]));
        host_idle_a();

        exp1 = model_a(0, 1000, 0);
        start_a(0, 1000, 0);
        wait_a("run1000", 1003, exp1);

        start_a(1020, 8, 7);
        wait_a("wrap_a", 11, model_a(1020, 8, 7));

        start_a(5, 0, -5);
        wait_a("len0", 1, 64'hFFFF_FFFF_FFFF_FFFB);

        // Host writes and start pulses while running must be ignored.
        start_a(0, 1000, 0);
        repeat (50) @(negedge clk);
        for (int k = 0; k < 16; k++) begin
            @(negedge clk);
            bus_a.controlArr          = 1'b1;
            bus_a.controlArrWEnable_a = 1'b1;
            bus_a.controlArrWEnable_b = 1'b1;
            bus_a.controlArrAddr_a    = AW'(k);
            bus_a.controlArrAddr_b    = AW'(k);
            bus_a.controlArrWData_a   = ~mem_a[k];
            bus_a.controlArrWData_b   = ~mem_b[k];
            bus_a.r_enable            = k[0];
        end
        @(negedge clk);
        bus_a.controlArr          = 1'b0;
        bus_a.controlArrWEnable_a = 1'b0;
        bus_a.controlArrWEnable_b = 1'b0;
        bus_a.r_enable            = 1'b1;
        @(negedge clk);
        bus_a.r_enable = 1'b0;
        wait_a("interlock", 1003, exp1);
        w0 = wen_a;
        repeat (20) @(posedge clk);
        #1;
        check("interlock_no_restart", 64'(wen_a - w0), 64'd0);
        check("interlock_idle_busy", {63'd0, bus_a.busy}, 64'd0);
        for (int k = 0; k < 16; k += 5) begin
            host_rd_a(k, ra, rb);
            check("interlock_array_a", 64'(ra), 64'(mem_a[k]));
            check("interlock_array_b", 64'(rb), 64'(mem_b[k]));
        end
        host_idle_a();

        // Reset pulse halfway through a long run.
        start_a(0, 1000, 0);
        repeat (500) @(posedge clk);
        #2;
        rst_n = 1'b0;
        #1;
        check("midreset_w_enable", {63'd0, bus_a.w_enable}, 64'd0);
        check("midreset_busy", {63'd0, bus_a.busy}, 64'd0);
        check("midreset_result", bus_a.result, 64'd0);
        @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        w0 = wen_a;
        repeat (600) @(posedge clk);
        #1;
        check("midreset_no_strobe", 64'(wen_a - w0), 64'd0);
        check("midreset_busy_later", {63'd0, bus_a.busy}, 64'd0);
        check("midreset_result_later", bus_a.result, 64'd0);
        start_a(0, 1000, 0);
        wait_a("after_reset", 1003, exp1);

        // Most negative operand squared.
        mem_a[0] = 27'h4000000;
        mem_b[0] = 27'h4000000;
        host_wr_a(0, mem_a[0], mem_b[0]);
        host_idle_a();
        start_a(0, 1, 0);
        wait_a("ext_signed", 4, 64'h0010_0000_0000_0000);

        for (int k = 0; k < 16; k++) begin
            host_wr_b(k, EW'(k + 1), EW'(1));
        end
        run_b("wrap_b", 14, 4, 0, 7, 64'd34);
        run_b("full_b", 3, 16, 1000, 19, 64'd1136);
        host_wr_b(0, 27'h7FFFFFF, 27'h7FFFFFF);
        run_b("ext_unsigned", 0, 1, 0, 4, 64'h003F_FFFF_F000_0001);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
